// File: rtl/audio_stream_buffer.sv
// rtl/audio_stream_buffer.sv - serial audio deserializer, sample FIFO and fixed-rate PWM playback
//
// Purpose: collects received_bit into PCM samples while audio_data_ready is high,
// buffers them in an on-chip FIFO and plays them out at SAMPLE_HZ on an 8-bit
// sample bus plus a PWM pin.
//
// Ports:
//   CLK_40               in   system clock
//   reset_n              in   asynchronous active-low reset
//   data_clk_rising_edge in   single-cycle bit-valid strobe
//   audio_data_ready     in   high while audio bits are being delivered
//   received_bit         in   serial data bit, sampled on the strobe
//   play_en              in   playback enable (level)
//   flush                in   synchronous single-cycle clear
//   sample_out           out  current sample (midscale when silent)
//   sample_strobe        out  one-cycle pulse when sample_out is loaded from the FIFO
//   pwm_out              out  PWM audio output
//   fifo_level           out  number of stored samples
//   almost_full          out  fifo_level >= FIFO_DEPTH-16
//   underrun             out  sticky: a playback tick found the FIFO empty
//   overflow             out  sticky: a sample was dropped because the FIFO was full

module audio_stream_buffer #(
  parameter int SAMPLE_W    = 8,
  parameter int FIFO_DEPTH  = 256,
  parameter int CLK_HZ      = 40000000,
  parameter int SAMPLE_HZ   = 8000,
  parameter int PRIME_LEVEL = 64,
  parameter int MSB_FIRST   = 1
) (
  input  logic                          CLK_40,
  input  logic                          reset_n,
  input  logic                          data_clk_rising_edge,
  input  logic                          audio_data_ready,
  input  logic                          received_bit,
  input  logic                          play_en,
  input  logic                          flush,
  output logic [SAMPLE_W-1:0]           sample_out,
  output logic                          sample_strobe,
  output logic                          pwm_out,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          almost_full,
  output logic                          underrun,
  output logic                          overflow
);

  localparam int PTR_W       = $clog2(FIFO_DEPTH);
  localparam int LVL_W       = PTR_W + 1;
  localparam int CNT_W       = (SAMPLE_W > 1) ? $clog2(SAMPLE_W) : 1;
  localparam int TICK_PERIOD = CLK_HZ / SAMPLE_HZ;
  localparam int TICK_W      = (TICK_PERIOD > 1) ? $clog2(TICK_PERIOD) : 1;

  localparam logic [SAMPLE_W-1:0] MIDSCALE  = {1'b1, {(SAMPLE_W-1){1'b0}}};
  localparam logic [CNT_W-1:0]    LAST_BIT  = CNT_W'(SAMPLE_W - 1);
  localparam logic [TICK_W-1:0]   TICK_LAST = TICK_W'(TICK_PERIOD - 1);
  localparam logic [LVL_W-1:0]    FULL_LVL  = LVL_W'(FIFO_DEPTH);
  localparam logic [LVL_W-1:0]    AF_LVL    = LVL_W'(FIFO_DEPTH - 16);
  localparam logic [LVL_W-1:0]    PRIME_LVL = LVL_W'(PRIME_LEVEL);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_PRIME = 2'd1;
  localparam logic [1:0] S_PLAY  = 2'd2;

  // Deserializer
  logic [SAMPLE_W-1:0] r_shift;
  logic [CNT_W-1:0]    r_bit_cnt;
  logic                r_ready_d;
  logic                r_wr_en;
  logic [SAMPLE_W-1:0] r_wr_data;

  // FIFO
  logic [SAMPLE_W-1:0] r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]    r_wr_ptr;
  logic [PTR_W-1:0]    r_rd_ptr;
  logic [LVL_W-1:0]    r_level;
  logic                r_overflow;

  // Playback
  logic [1:0]          r_state;
  logic [TICK_W-1:0]   r_tick_cnt;
  logic [SAMPLE_W-1:0] r_sample_out;
  logic                r_sample_strobe;
  logic                r_underrun;

  // PWM
  logic [SAMPLE_W-1:0] r_pwm_cnt;
  logic                r_pwm_out;

  logic                w_bit_accept;
  logic                w_ready_fall;
  logic [SAMPLE_W-1:0] w_shift_next;
  logic                w_empty;
  logic                w_full;
  logic                w_tick;
  logic                w_pop;
  logic                w_push;
  logic [SAMPLE_W-1:0] w_rd_data;

  assign w_bit_accept = data_clk_rising_edge && audio_data_ready;
  assign w_ready_fall = r_ready_d && !audio_data_ready;

  always_comb begin
    w_shift_next = r_shift;
    if (MSB_FIRST != 0) begin
      // After SAMPLE_W left shifts the first bit received sits in the MSB.
      w_shift_next = {r_shift[SAMPLE_W-2:0], received_bit};
    end else begin
      w_shift_next = {received_bit, r_shift[SAMPLE_W-1:1]};
    end
  end

  always_ff @(posedge CLK_40 or negedge reset_n) begin
    if (!reset_n) begin
      r_shift   <= '0;
      r_bit_cnt <= '0;
      r_ready_d <= 1'b0;
      r_wr_en   <= 1'b0;
      r_wr_data <= '0;
    end else begin
      r_ready_d <= audio_data_ready;
      r_wr_en   <= 1'b0;
      if (flush) begin
        r_shift   <= '0;
        r_bit_cnt <= '0;
      end else if (w_ready_fall) begin
        // End of a burst: drop any partial sample so the next burst starts aligned.
        r_bit_cnt <= '0;
      end else if (w_bit_accept) begin
        r_shift <= w_shift_next;
        if (r_bit_cnt == LAST_BIT) begin
          r_wr_en   <= 1'b1;
          r_wr_data <= w_shift_next;
          r_bit_cnt <= '0;
        end else begin
          r_bit_cnt <= r_bit_cnt + 1'b1;
        end
      end
    end
  end

  assign w_empty   = (r_level == '0);
  assign w_full    = (r_level == FULL_LVL);
  assign w_tick    = (r_state != S_IDLE) && (r_tick_cnt == TICK_LAST);
  // A pop only happens on a tick that the FSM will actually service this cycle.
  assign w_pop     = !flush && (r_state == S_PLAY) && play_en && w_tick && !w_empty;
  // A full FIFO still accepts a word when a pop frees a slot in the same cycle.
  assign w_push    = !flush && r_wr_en && (!w_full || w_pop);
  assign w_rd_data = r_mem[r_rd_ptr];

  always_ff @(posedge CLK_40) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= r_wr_data;
    end
  end

  always_ff @(posedge CLK_40 or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_level    <= '0;
      r_overflow <= 1'b0;
    end else if (flush) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_level    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      if (w_push && !w_pop) begin
        r_level <= r_level + 1'b1;
      end else if (w_pop && !w_push) begin
        r_level <= r_level - 1'b1;
      end
      if (r_wr_en && w_full && !w_pop) begin
        r_overflow <= 1'b1;
      end
    end
  end

  // Sample-rate divider; held at zero while idle so each session starts a fresh period.
  always_ff @(posedge CLK_40 or negedge reset_n) begin
    if (!reset_n) begin
      r_tick_cnt <= '0;
    end else if (flush || (r_state == S_IDLE) || (r_tick_cnt == TICK_LAST)) begin
      r_tick_cnt <= '0;
    end else begin
      r_tick_cnt <= r_tick_cnt + 1'b1;
    end
  end

  always_ff @(posedge CLK_40 or negedge reset_n) begin
    if (!reset_n) begin
      r_state         <= S_IDLE;
      r_sample_out    <= MIDSCALE;
      r_sample_strobe <= 1'b0;
      r_underrun      <= 1'b0;
    end else begin
      r_sample_strobe <= 1'b0;
      if (flush) begin
        r_state      <= S_IDLE;
        r_sample_out <= MIDSCALE;
        r_underrun   <= 1'b0;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (play_en) begin
              r_state <= S_PRIME;
            end
          end
          S_PRIME: begin
            if (!play_en) begin
              r_state <= S_IDLE;
            end else if (r_level >= PRIME_LVL) begin
              r_state <= S_PLAY;
            end
          end
          S_PLAY: begin
            if (!play_en) begin
              r_state      <= S_IDLE;
              r_sample_out <= MIDSCALE;
            end else if (w_tick) begin
              if (!w_empty) begin
                r_sample_out    <= w_rd_data;
                r_sample_strobe <= 1'b1;
              end else begin
                // Starved: output silence and keep waiting for data in PLAY.
                r_sample_out <= MIDSCALE;
                r_underrun   <= 1'b1;
              end
            end
          end
          default: begin
            r_state      <= S_IDLE;
            r_sample_out <= MIDSCALE;
          end
        endcase
      end
    end
  end

  always_ff @(posedge CLK_40 or negedge reset_n) begin
    if (!reset_n) begin
      r_pwm_cnt <= '0;
      r_pwm_out <= 1'b0;
    end else begin
      r_pwm_cnt <= r_pwm_cnt + 1'b1;
      r_pwm_out <= (r_pwm_cnt < r_sample_out);
    end
  end

  assign sample_out    = r_sample_out;
  assign sample_strobe = r_sample_strobe;
  assign pwm_out       = r_pwm_out;
  assign fifo_level    = r_level;
  assign almost_full   = (r_level >= AF_LVL);
  assign underrun      = r_underrun;
  assign overflow      = r_overflow;

endmodule

// File: tb/tb_audio_stream_buffer.sv
// tb/tb_audio_stream_buffer.sv - self-checking bench for audio_stream_buffer

module tb_audio_stream_buffer;

  localparam int TP    = 20;
  localparam int DEPTH = 256;

  logic       CLK_40 = 1'b0;
  logic       reset_n = 1'b0;
  logic       data_clk_rising_edge = 1'b0;
  logic       audio_data_ready = 1'b0;
  logic       received_bit = 1'b0;
  logic       play_en = 1'b0;
  logic       flush = 1'b0;
  logic [7:0] sample_out;
  logic       sample_strobe;
  logic       pwm_out;
  logic [8:0] fifo_level;
  logic       almost_full;
  logic       underrun;
  logic       overflow;

  always #5 CLK_40 = ~CLK_40;

  audio_stream_buffer #(
    .SAMPLE_W(8), .FIFO_DEPTH(DEPTH), .CLK_HZ(40000000), .SAMPLE_HZ(2000000),
    .PRIME_LEVEL(64), .MSB_FIRST(1)
  ) dut (
    .CLK_40(CLK_40), .reset_n(reset_n), .data_clk_rising_edge(data_clk_rising_edge),
    .audio_data_ready(audio_data_ready), .received_bit(received_bit), .play_en(play_en),
    .flush(flush), .sample_out(sample_out), .sample_strobe(sample_strobe), .pwm_out(pwm_out),
    .fifo_level(fifo_level), .almost_full(almost_full), .underrun(underrun), .overflow(overflow)
  );

  int         n_cmp = 0;
  int         n_fail = 0;
  logic [7:0] q[$];
  int         strobe_cnt = 0;
  int         last_strobe_cyc = 0;
  int         cyc = 0;
  int         edge_k = 0;
  int         pwm_err = 0;
  logic [7:0] prev_sample = 8'h80;
  logic [7:0] expv;
  int         c0, base, hi, t, pc;
  logic [7:0] r;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(posedge CLK_40) cyc = cyc + 1;

  // Edges since reset release: the PWM counter value before edge k is (k-1) mod 256.
  always @(posedge CLK_40 or negedge reset_n) begin
    if (!reset_n) edge_k = 0;
    else edge_k = edge_k + 1;
  end

  always @(negedge CLK_40) begin
    if (!reset_n) begin
      prev_sample = 8'h80;
    end else begin
      if (edge_k > 0) begin
        pc = (edge_k - 1) % 256;
        if (pwm_out !== ((pc < int'(prev_sample)) ? 1'b1 : 1'b0)) pwm_err++;
      end
      prev_sample = sample_out;
      if (sample_strobe) begin
        strobe_cnt++;
        last_strobe_cyc = cyc;
        if (q.size() == 0) begin
          chk("strobe_without_data", 32'd1, 32'd0);
        end else begin
          expv = q.pop_front();
          chk("pop_data", sample_out, expv);
        end
      end
    end
  end

  task automatic send_bit(input logic b);
    @(negedge CLK_40);
    received_bit = b;
    data_clk_rising_edge = 1'b1;
    @(negedge CLK_40);
    data_clk_rising_edge = 1'b0;
    repeat ($urandom_range(0, 2)) @(negedge CLK_40);
  endtask

  task automatic send_byte(input logic [7:0] b);
    audio_data_ready = 1'b1;
    for (int i = 7; i >= 0; i--) send_bit(b[i]);
    if (q.size() < DEPTH) q.push_back(b);
  endtask

  task automatic wait_n(input int n);
    repeat (n) @(negedge CLK_40);
    #1;
  endtask

  task automatic wait_strobe(input int budget);
    int start;
    int tt;
    start = strobe_cnt;
    tt = 0;
    while (strobe_cnt == start && tt < budget) begin
      @(negedge CLK_40);
      #1;
      tt++;
    end
    chk("strobe_wait", 32'(strobe_cnt != start), 32'd1);
  endtask

  initial begin
    // Reset state
    #12;
    chk("rst_sample", sample_out, 8'h80);
    chk("rst_strobe", sample_strobe, 0);
    chk("rst_pwm", pwm_out, 0);
    chk("rst_level", fifo_level, 0);
    chk("rst_af", almost_full, 0);
    chk("rst_underrun", underrun, 0);
    chk("rst_overflow", overflow, 0);
    @(posedge CLK_40); #2;
    reset_n = 1'b1;

    // play_en with no data: stays priming, silent, no underrun
    @(negedge CLK_40);
    play_en = 1'b1;
    wait_n(3 * TP);
    chk("prime_no_strobe", strobe_cnt, 0);
    chk("prime_sample", sample_out, 8'h80);
    chk("prime_underrun", underrun, 0);

    // 64 ascending bytes: playback starts only once 64 are buffered
    for (int b = 0; b < 63; b++) send_byte(8'(b));
    wait_n(3);
    chk("prime_63_no_strobe", strobe_cnt, 0);
    chk("prime_63_level", fifo_level, 63);
    send_byte(8'h3F);
    wait_strobe(4 * TP);
    chk("first_pop_level", fifo_level, 63);
    c0 = last_strobe_cyc;
    for (int i = 1; i < 4; i++) begin
      wait_strobe(2 * TP);
      chk("tick_spacing", last_strobe_cyc - c0, TP);
      chk("level_dec", fifo_level, 63 - i);
      c0 = last_strobe_cyc;
    end
    for (int i = 4; i < 64; i++) wait_strobe(2 * TP);
    chk("drain_count", strobe_cnt, 64);
    chk("drain_level", fifo_level, 0);
    chk("drain_underrun", underrun, 0);

    // Empty FIFO on a tick: silence and sticky underrun, no strobe
    wait_n(TP + 3);
    chk("underrun_set", underrun, 1);
    chk("underrun_sample", sample_out, 8'h80);
    chk("underrun_no_strobe", strobe_cnt, 64);

    // Midscale for 256 cycles: PWM high exactly half the time
    hi = 0;
    for (int i = 0; i < 256; i++) begin
      @(negedge CLK_40); #1;
      if (pwm_out === 1'b1) hi++;
    end
    chk("pwm_midscale_duty", hi, 128);

    // One new byte restores normal pops
    r = 8'($urandom_range(0, 127));
    send_byte(r);
    wait_strobe(3 * TP);
    chk("recover_sample", sample_out, r);
    chk("underrun_sticky", underrun, 1);
    @(negedge CLK_40);
    play_en = 1'b0;
    wait_n(2);
    chk("stop_midscale", sample_out, 8'h80);
    @(negedge CLK_40); flush = 1'b1;
    @(negedge CLK_40); flush = 1'b0;
    wait_n(1);
    chk("flush1_underrun", underrun, 0);
    chk("flush1_level", fifo_level, 0);

    // Partial word dropped when audio_data_ready falls
    audio_data_ready = 1'b1;
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b0); send_bit(1'b0);
    @(negedge CLK_40);
    audio_data_ready = 1'b0;
    wait_n(3);
    send_byte(8'h3C);
    wait_n(3);
    chk("partial_level", fifo_level, 1);

    // Fill to full, check almost_full boundary, then overflow
    for (int k = 1; k < 256; k++) begin
      send_byte(8'($urandom_range(0, 255)));
      if (q.size() == 239) begin
        wait_n(3);
        chk("af_239", almost_full, 0);
      end
      if (q.size() == 240) begin
        wait_n(3);
        chk("af_240", almost_full, 1);
      end
    end
    wait_n(3);
    chk("full_level", fifo_level, 256);
    chk("full_af", almost_full, 1);
    chk("full_no_overflow", overflow, 0);
    send_byte(8'($urandom_range(0, 255)));
    wait_n(3);
    chk("overflow_set", overflow, 1);
    chk("overflow_level", fifo_level, 256);
    chk("overflow_af", almost_full, 1);

    // Read everything back: 0x3C first, 257th byte never appears
    base = strobe_cnt;
    @(negedge CLK_40);
    play_en = 1'b1;
    t = 0;
    while (q.size() > 0 && t < (DEPTH + 4) * TP) begin
      @(negedge CLK_40); #1;
      t++;
    end
    wait_n(TP + 3);
    chk("readout_count", strobe_cnt - base, 256);
    chk("readout_level", fifo_level, 0);

    // Flush mid-stream while filling
    @(negedge CLK_40);
    play_en = 1'b0;
    for (int k = 0; k < 5; k++) send_byte(8'($urandom_range(0, 255)));
    send_bit(1'b1); send_bit(1'b1); send_bit(1'b0);
    chk("pre_flush_overflow", overflow, 1);
    @(negedge CLK_40); flush = 1'b1; q.delete();
    @(negedge CLK_40); flush = 1'b0;
    wait_n(1);
    chk("flush_level", fifo_level, 0);
    chk("flush_overflow", overflow, 0);
    chk("flush_underrun", underrun, 0);
    chk("flush_sample", sample_out, 8'h80);
    chk("flush_af", almost_full, 0);

    // Post-flush stream: leftover partial bits must not shift the data
    base = strobe_cnt;
    play_en = 1'b1;
    for (int k = 0; k < 64; k++) send_byte(8'($urandom_range(0, 255)));
    for (int k = 0; k < 10; k++) wait_strobe(3 * TP);

    // Reset mid-playback: everything aborts, no further samples
    @(posedge CLK_40); #2;
    reset_n = 1'b0;
    q.delete();
    #1;
    chk("midrst_sample", sample_out, 8'h80);
    chk("midrst_strobe", sample_strobe, 0);
    chk("midrst_level", fifo_level, 0);
    chk("midrst_pwm", pwm_out, 0);
    base = strobe_cnt;
    wait_n(3);
    @(posedge CLK_40); #2;
    reset_n = 1'b1;
    wait_n(3 * TP);
    chk("postrst_no_strobe", strobe_cnt - base, 0);
    chk("postrst_sample", sample_out, 8'h80);

    chk("pwm_model", pwm_err, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
